// File: rtl/xor_array_decoder_if.sv
// Valid/ready frame channel carrying LANES packed lane symbols.
interface xor_array_decoder_if #(
   parameter int unsigned LANES = 4,
   parameter int unsigned WIDTH = 2
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data [0:LANES-1];

   // Producer side drives valid/data, consumer side drives ready.
   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/xor_array_decoder.sv
// Sequential differential-XOR decoder: one lane per clock, d[i] = e[i] ^ d[i-1], d[-1] = SEED.
module xor_array_decoder #(
   parameter int unsigned           LANES = 4,
   parameter int unsigned           WIDTH = 2,
   parameter logic [WIDTH-1:0]      SEED  = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   xor_array_decoder_if.slave        in_if,
   xor_array_decoder_if.master       out_if,
   output logic                      busy
);

   localparam int unsigned KW    = $clog2(LANES);
   localparam logic [KW-1:0] KLast = KW'(LANES - 1);

   typedef enum logic [1:0] {StIdle, StDecode, StOutput} state_e;

   state_e           state_q, state_d;
   logic [KW-1:0]    k_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] frame_q    [0:LANES-1];
   logic [WIDTH-1:0] out_data_q [0:LANES-1];

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: accept in IDLE, walk all lanes, hold result until consumed.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (in_if.valid)       state_d = StDecode;
         StDecode: if (k_q == KLast)      state_d = StOutput;
         StOutput: if (out_if.ready)      state_d = StIdle;
         default:                         state_d = StIdle;
      endcase
   end

   // Datapath: capture frame on accept, then fold one lane per cycle into the chain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k_q   <= '0;
         acc_q <= SEED;
         for (int i = 0; i < LANES; i++) begin
            frame_q[i]    <= '0;
            out_data_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_if.valid) begin
                  frame_q <= in_if.data;
                  acc_q   <= SEED;
                  k_q     <= '0;
               end
            end
            StDecode: begin
               out_data_q[k_q] <= frame_q[k_q] ^ acc_q;
               acc_q           <= frame_q[k_q] ^ acc_q;
               // Counter parks on the last lane rather than wrapping.
               if (k_q != KLast) begin
                  k_q <= k_q + KW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decode from the state register only; in_ready is also gated by reset.
   always_comb begin
      in_if.ready  = rst_n && (state_q == StIdle);
      out_if.valid = (state_q == StOutput);
      out_if.data  = out_data_q;
      busy         = (state_q != StIdle);
   end

endmodule

// File: tb/tb_xor_array_decoder.sv
// Self-checking bench: two decoders (SEED 0 and SEED 2) driven in lockstep against a prefix-XOR model.
module tb_xor_array_decoder;

   localparam int unsigned L = 4;
   localparam int unsigned W = 2;

   typedef logic [W-1:0] frame_t [0:L-1];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy0, busy1;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   int last_acc = 0;

   xor_array_decoder_if #(.LANES(L), .WIDTH(W)) in0  ();
   xor_array_decoder_if #(.LANES(L), .WIDTH(W)) out0 ();
   xor_array_decoder_if #(.LANES(L), .WIDTH(W)) in1  ();
   xor_array_decoder_if #(.LANES(L), .WIDTH(W)) out1 ();

   xor_array_decoder #(.LANES(L), .WIDTH(W), .SEED(2'd0)) u_dut0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_if  (in0),
      .out_if (out0),
      .busy   (busy0)
   );

   xor_array_decoder #(.LANES(L), .WIDTH(W), .SEED(2'd2)) u_dut1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_if  (in1),
      .out_if (out1),
      .busy   (busy1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Decoded lane i is the seed XORed with every encoded lane 0..i.
   function automatic logic [W-1:0] ref_lane(frame_t e, logic [W-1:0] seed, int i);
      logic [W-1:0] x;
      x = seed;
      for (int j = 0; j <= i; j++) x = x ^ e[j];
      return x;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic v, frame_t f);
      in0.valid = v;
      in1.valid = v;
      for (int i = 0; i < L; i++) begin
         in0.data[i] = f[i];
         in1.data[i] = f[i];
      end
   endtask

   task automatic set_ready(logic r);
      out0.ready = r;
      out1.ready = r;
   endtask

   task automatic chk_in_ready(string tag, logic exp);
      chk({tag, "_in_ready0"}, {31'b0, in0.ready}, {31'b0, exp});
      chk({tag, "_in_ready1"}, {31'b0, in1.ready}, {31'b0, exp});
   endtask

   task automatic chk_frame_out(string tag, frame_t f);
      chk({tag, "_out_valid0"}, {31'b0, out0.valid}, 32'd1);
      chk({tag, "_out_valid1"}, {31'b0, out1.valid}, 32'd1);
      chk({tag, "_busy0"}, {31'b0, busy0}, 32'd1);
      chk({tag, "_busy1"}, {31'b0, busy1}, 32'd1);
      for (int i = 0; i < L; i++) begin
         chk($sformatf("%s_d0_lane%0d", tag, i), {30'b0, out0.data[i]},
             {30'b0, ref_lane(f, 2'd0, i)});
         chk($sformatf("%s_d1_lane%0d", tag, i), {30'b0, out1.data[i]},
             {30'b0, ref_lane(f, 2'd2, i)});
      end
   endtask

   task automatic chk_reset_state(string tag);
      chk_in_ready(tag, 1'b0);
      chk({tag, "_out_valid0"}, {31'b0, out0.valid}, 32'd0);
      chk({tag, "_out_valid1"}, {31'b0, out1.valid}, 32'd0);
      chk({tag, "_busy0"}, {31'b0, busy0}, 32'd0);
      chk({tag, "_busy1"}, {31'b0, busy1}, 32'd0);
      for (int i = 0; i < L; i++) begin
         chk($sformatf("%s_d0_lane%0d", tag, i), {30'b0, out0.data[i]}, 32'd0);
         chk($sformatf("%s_d1_lane%0d", tag, i), {30'b0, out1.data[i]}, 32'd0);
      end
   endtask

   // One full frame: accept, decode latency, optional backpressure, output handshake.
   task automatic do_frame(string tag, frame_t f, logic pre_ready, int hold, int exp_gap);
      int     n;
      frame_t junk;
      set_ready(pre_ready);
      drive(1'b1, f);
      n = 0;
      while (!in0.ready && n < 20) begin
         step();
         n++;
      end
      chk_in_ready({tag, "_pre_accept"}, 1'b1);
      step();
      if (exp_gap > 0) chk({tag, "_frame_gap"}, cyc - last_acc, exp_gap);
      last_acc = cyc;
      // Keep in_valid high with garbage: must be ignored while busy.
      for (int i = 0; i < L; i++) junk[i] = W'($urandom);
      drive(1'b1, junk);
      n = 0;
      while (!out0.valid && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_latency"}, n, L);
      chk_frame_out(tag, f);
      chk_in_ready({tag, "_busy"}, 1'b0);
      for (int h = 0; h < hold; h++) begin
         step();
         chk_frame_out($sformatf("%s_hold%0d", tag, h), f);
         chk_in_ready($sformatf("%s_hold%0d", tag, h), 1'b0);
      end
      set_ready(1'b1);
      step();
      chk({tag, "_post_valid0"}, {31'b0, out0.valid}, 32'd0);
      chk({tag, "_post_valid1"}, {31'b0, out1.valid}, 32'd0);
      chk({tag, "_post_busy0"}, {31'b0, busy0}, 32'd0);
      chk_in_ready({tag, "_post"}, 1'b1);
      drive(1'b0, f);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t f_basic, f_alt, f_zero, f_rand;
      f_basic = '{2'd1, 2'd3, 2'd0, 2'd2};
      f_alt   = '{2'd3, 2'd3, 2'd3, 2'd3};
      f_zero  = '{2'd0, 2'd0, 2'd0, 2'd0};

      // Reset state
      rst_n = 1'b0;
      drive(1'b0, f_zero);
      set_ready(1'b0);
      step();
      step();
      chk_reset_state("reset");
      rst_n = 1'b1;
      #1;
      chk_in_ready("reset_release", 1'b1);
      step();

      // Basic decode and back-to-back frames
      do_frame("basic", f_basic, 1'b0, 0, 0);
      do_frame("alt", f_alt, 1'b1, 0, 0);
      do_frame("zero", f_zero, 1'b1, 0, L + 2);

      // Backpressure, then repeated frames to confirm the seed is reapplied
      do_frame("bp", f_basic, 1'b0, 5, 0);
      do_frame("seed_a", f_basic, 1'b1, 0, 0);
      do_frame("seed_b", f_basic, 1'b1, 0, L + 2);

      // Reset during decode
      drive(1'b1, f_alt);
      step();
      drive(1'b0, f_alt);
      step();
      rst_n = 1'b0;
      step();
      chk_reset_state("mid_reset");
      rst_n = 1'b1;
      #1;
      chk_in_ready("mid_reset_release", 1'b1);
      do_frame("after_abort", f_basic, 1'b1, 0, 0);

      // Handshake offered while in reset is not taken
      rst_n = 1'b0;
      drive(1'b1, f_basic);
      step();
      step();
      chk_reset_state("hs_in_reset");
      rst_n = 1'b1;
      do_frame("after_hs", f_basic, 1'b1, 0, 0);

      // Random frames with random backpressure
      for (int r = 0; r < 20; r++) begin
         logic pr;
         int   hd;
         for (int i = 0; i < L; i++) f_rand[i] = W'($urandom);
         pr = 1'($urandom);
         hd = pr ? 0 : int'($urandom_range(0, 3));
         do_frame($sformatf("rand%0d", r), f_rand, pr, hd, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
